// File: rtl/grf_write_arbiter_pkg.sv
// Shared definitions for the GRF write-port arbiter: register-file geometry
// and the arbiter mode encoding.
package grf_write_arbiter_pkg;

  localparam int unsigned GRF_ADDR_W = 5;
  localparam int unsigned GRF_DATA_W = 32;
  localparam int unsigned GRF_NREG   = 32;

  typedef enum logic {
    ARB_NORM  = 1'b0,
    ARB_FORCE = 1'b1
  } arb_mode_e;

  // $0 is hard-wired zero: never written, never busy.
  function automatic logic is_zero_reg(input logic [GRF_ADDR_W-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/grf_write_arbiter_if.sv
// Bus bundle between the core (master) and the GRF write arbiter (slave):
// WB write request, aux valid/ready result path, scoreboard issue/lookup,
// and the signals forwarded to the GRF write port and bypass inputs.
interface grf_write_arbiter_if;
  import grf_write_arbiter_pkg::*;

  logic                  pipe_we;
  logic [GRF_ADDR_W-1:0] pipe_addr;
  logic [GRF_DATA_W-1:0] pipe_data;
  logic                  pipe_stall;

  logic                  aux_valid;
  logic [GRF_ADDR_W-1:0] aux_addr;
  logic [GRF_DATA_W-1:0] aux_data;
  logic                  aux_ready;

  logic                  issue_valid;
  logic [GRF_ADDR_W-1:0] issue_addr;
  logic                  issue_ready;

  logic [GRF_ADDR_W-1:0] rs;
  logic [GRF_ADDR_W-1:0] rt;
  logic                  rs_busy;
  logic                  rt_busy;

  logic                  reg_write;
  logic [GRF_ADDR_W-1:0] write_addr;
  logic [GRF_DATA_W-1:0] write_data;
  logic                  bypass_rs_grf;
  logic                  bypass_rt_grf;

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output aux_valid, aux_addr, aux_data,
    output issue_valid, issue_addr,
    output rs, rt,
    input  pipe_stall, aux_ready, issue_ready, rs_busy, rt_busy,
    input  reg_write, write_addr, write_data, bypass_rs_grf, bypass_rt_grf
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  aux_valid, aux_addr, aux_data,
    input  issue_valid, issue_addr,
    input  rs, rt,
    output pipe_stall, aux_ready, issue_ready, rs_busy, rt_busy,
    output reg_write, write_addr, write_data, bypass_rs_grf, bypass_rt_grf
  );

endinterface

// File: rtl/grf_write_arbiter_scoreboard.sv
// grf_scoreboard: one busy bit per GRF register, marking registers whose
// result will arrive later through the aux port. Set on issue, cleared on the
// aux grant; a set and clear of the same register in one cycle leaves it busy.
module grf_scoreboard
  import grf_write_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_i,
  input  logic [GRF_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [GRF_ADDR_W-1:0] clr_addr_i,
  input  logic [GRF_ADDR_W-1:0] rs_i,
  input  logic [GRF_ADDR_W-1:0] rt_i,
  input  logic [GRF_ADDR_W-1:0] chk_addr_i,
  output logic                  rs_busy_o,
  output logic                  rt_busy_o,
  output logic                  chk_busy_o
);

  logic [GRF_NREG-1:0] busy_q;
  logic [GRF_NREG-1:0] busy_d;
  logic [GRF_NREG-1:0] set_mask;
  logic [GRF_NREG-1:0] clr_mask;

  // Next busy vector: clear first, then set, so a same-cycle set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_i && !is_zero_reg(set_addr_i)) set_mask[set_addr_i] = 1'b1;
    if (clr_i) clr_mask[clr_addr_i] = 1'b1;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // Busy vector register, discarded asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Lookups; $0 never reports busy.
  always_comb begin
    rs_busy_o  = !is_zero_reg(rs_i)       && busy_q[rs_i];
    rt_busy_o  = !is_zero_reg(rt_i)       && busy_q[rt_i];
    chk_busy_o = !is_zero_reg(chk_addr_i) && busy_q[chk_addr_i];
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: owns the single GRF write port. The WB stage has
// priority; the aux unit (valid/ready) gets idle slots and is forced through
// after MAX_WAIT consecutive denied cycles. Also hosts the busy scoreboard.
// Optional trace output is enabled with the macro GRF_ARB_TRACE_EN.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  grf_write_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  arb_mode_e             mode_q;
  arb_mode_e             mode_d;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic [CNT_W-1:0]      wait_cnt_d;

  logic                  force_act;
  logic                  aux_gnt;
  logic                  pipe_gnt;
  logic                  any_gnt;
  logic [GRF_ADDR_W-1:0] gnt_addr;
  logic [GRF_DATA_W-1:0] gnt_data;
  logic                  wr_en;
  logic                  rs_busy_sb;
  logic                  rt_busy_sb;
  logic                  issue_busy_sb;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= MAX_WAIT_C) return MAX_WAIT_C;
    return v + CNT_W'(1);
  endfunction

  // Mode and wait-counter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= ARB_NORM;
      wait_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state: count consecutive denied aux cycles; force once the count hits MAX_WAIT.
  always_comb begin
    wait_cnt_d = '0;
    if (bus.aux_valid && !aux_gnt) wait_cnt_d = sat_inc(wait_cnt_q);
    mode_d = (wait_cnt_d == MAX_WAIT_C) ? ARB_FORCE : ARB_NORM;
  end

  // Grant decision and write-port mux; everything is held off while reset is high.
  always_comb begin
    force_act = (mode_q == ARB_FORCE) && bus.aux_valid;
    aux_gnt   = !reset && bus.aux_valid && (force_act || !bus.pipe_we);
    pipe_gnt  = !reset && bus.pipe_we && !force_act;
    any_gnt   = aux_gnt || pipe_gnt;
    gnt_addr  = aux_gnt ? bus.aux_addr : bus.pipe_addr;
    gnt_data  = aux_gnt ? bus.aux_data : bus.pipe_data;
    wr_en     = any_gnt && !is_zero_reg(gnt_addr);

    bus.aux_ready     = aux_gnt;
    bus.pipe_stall    = !reset && bus.pipe_we && force_act;
    bus.reg_write     = wr_en;
    bus.write_addr    = gnt_addr;
    bus.write_data    = gnt_data;
    bus.bypass_rs_grf = wr_en && (gnt_addr == bus.rs);
    bus.bypass_rt_grf = wr_en && (gnt_addr == bus.rt);
    bus.rs_busy       = !reset && rs_busy_sb;
    bus.rt_busy       = !reset && rt_busy_sb;
    bus.issue_ready   = !issue_busy_sb;
  end

  grf_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_i      (bus.issue_valid),
    .set_addr_i (bus.issue_addr),
    .clr_i      (aux_gnt),
    .clr_addr_i (bus.aux_addr),
    .rs_i       (bus.rs),
    .rt_i       (bus.rt),
    .chk_addr_i (bus.issue_addr),
    .rs_busy_o  (rs_busy_sb),
    .rt_busy_o  (rt_busy_sb),
    .chk_busy_o (issue_busy_sb)
  );

`ifdef GRF_ARB_TRACE_EN
  // Trace each committed write and each cycle the pipe is held for a forced aux write.
  always @(posedge clk) begin
    if (!reset) begin
      if (pipe_gnt && !is_zero_reg(bus.pipe_addr))
        $display("pipe $%0d <= %h", bus.pipe_addr, bus.pipe_data);
      if (aux_gnt && !is_zero_reg(bus.aux_addr))
        $display("aux $%0d <= %h", bus.aux_addr, bus.aux_data);
      if (force_act && bus.pipe_we)
        $display("grf arb: force aux, pipe stalled");
    end
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: doc/grf_write_arbiter.md
Name: grf_write_arbiter

Overview:
- Owns the single GRF write port and shares it between two requesters:
  - the pipeline WB stage, which has priority and no ready signal;
  - one long-latency auxiliary unit (mult/div result, miss-load return), which uses a valid/ready handshake.
- Keeps a 32-entry scoreboard of registers with aux writes outstanding, for hazard stalls.
- Drives the GRF reg_write/write_addr/write_data and bypass_rs_grf/bypass_rt_grf inputs.

Parameters:
- MAX_WAIT, 4: consecutive denied aux cycles before the aux request is forced through (range 1..15).
- CNT_W, 4: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pipe_we  in  1  WB stage wants to write this cycle.
- pipe_addr  in  5  WB destination register.
- pipe_data  in  32  WB data.
- pipe_stall  out  1  WB write not taken this cycle; pipeline holds WB and retries.
- aux_valid  in  1  aux unit offers a result.
- aux_addr  in  5  aux destination register.
- aux_data  in  32  aux data.
- aux_ready  out  1  aux result accepted this cycle.
- issue_valid  in  1  a long-latency op targeting issue_addr is dispatched.
- issue_addr  in  5  destination of the dispatched op.
- issue_ready  out  1  issue_addr not already busy (always 1 for $0).
- rs  in  5  decode-stage source register.
- rt  in  5  decode-stage source register.
- rs_busy  out  1  busy[rs]; always 0 for $0.
- rt_busy  out  1  busy[rt]; always 0 for $0.
- reg_write  out  1  to GRF.
- write_addr  out  5  to GRF.
- write_data  out  32  to GRF.
- bypass_rs_grf  out  1  to GRF.
- bypass_rt_grf  out  1  to GRF.

Behaviour:
- State:
  - busy[31:0] register;
  - wait_cnt (CNT_W bits);
  - mode ∈ {NORM, FORCE}.
  - All clear/NORM while reset is high, applied asynchronously.
- Port outputs are combinational from inputs and state. While reset is high, reg_write, aux_ready, pipe_stall, rs_busy and rt_busy are 0.
- Grant in NORM:
  - pipe_we=1 → pipe granted; aux_ready=0.
  - pipe_we=0 and aux_valid=1 → aux granted; aux_ready=1.
- Grant in FORCE:
  - aux_valid=1 → aux granted; pipe_stall = pipe_we.
  - aux_valid=0 (unit withdrew its request) → behave as NORM.
- Write port:
  - reg_write=1 iff a grant is made and the granted addr ≠ 0.
  - write_addr/write_data come from the granted source.
  - A grant to $0 still completes the handshake but performs no write.
- Bypass: bypass_rs_grf = reg_write && write_addr==rs, evaluated against the granted write (same for rt). A stalled pipe write never bypasses.
- wait_cnt:
  - Increments on cycles where aux_valid=1 and aux_ready=0.
  - Clears on an aux grant or when aux_valid=0.
  - Saturates at MAX_WAIT.
- mode:
  - mode=FORCE when the next-state wait_cnt == MAX_WAIT; otherwise NORM.
  - Effect: aux is guaranteed a grant within MAX_WAIT+1 cycles of valid.
- Scoreboard:
  - issue_valid && issue_addr≠0 sets busy[issue_addr] at the next edge.
  - An aux grant clears busy[aux_addr] at the next edge.
  - Set and clear on the same address in the same cycle → set wins.
  - Issue to a busy register is a protocol violation; the issuer must check issue_ready. State stays busy.
- Aux handshake: aux_valid must stay high with stable addr/data until aux_ready. Single-cycle accept; no buffering.
- Reset mid-operation: pending aux request and busy bits are discarded. Aux and pipe restart from idle.

Optional Feature:
- GRF_ARB_TRACE_EN
  - Defined: each granted write with addr≠0 prints "pipe $%d <= %h" or "aux $%d <= %h" at the clock edge. Each FORCE cycle with pipe_stall=1 prints "grf arb: force aux, pipe stalled".
  - Undefined: no simulation output; logic is identical.

Decomposition:
- Shared package: GRF_ADDR_W=5, GRF_DATA_W=32, GRF_NREG=32, mode encoding ARB_NORM/ARB_FORCE.
- One natural sub-module: grf_scoreboard, holding the busy vector with set/clear/lookup ports (issue, clear, rs, rt).
- The arbiter, wait counter and port mux stay in the top.

Test Plan:
- Pipe only: pipe_we=1, addr=5, data=0xA5 → reg_write=1, write_addr=5, write_data=0xA5, pipe_stall=0. With rs=5, bypass_rs_grf=1.
- Aux idle slot: pipe_we=0; aux_valid=1, addr=9, data=0x1234 → aux_ready=1 same cycle, write to $9. busy[9], set by an earlier issue, clears next cycle.
- Starvation, MAX_WAIT=4: pipe_we=1 every cycle and aux_valid=1 from cycle 0 → aux_ready=0 for cycles 0–3. Cycle 4: aux_ready=1, pipe_stall=1, write_addr=aux_addr. Cycle 5: pipe granted, wait_cnt=0.
- Scoreboard: issue_valid to $7 → next cycle issue_ready=0 for addr 7, rs=7 gives rs_busy=1. Aux grant to $7 together with a new issue to $7 → busy[7] stays 1.
- $0 handling: issue $0 → no busy bit set. Aux to $0 → aux_ready=1, reg_write=0. rs=0 → rs_busy=0 and bypass_rs_grf=0.
- Async reset: with busy[3]=1 and wait_cnt=3, pulse reset between edges → busy=0, wait_cnt=0 immediately, aux_ready=0 while reset is high.
